// File: rtl/pipeline_display_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_display_driver_pkg
//  Description : Shared constants for the 4-digit 7-segment display driver.
//  Revision    : 1.0
// ============================================================================
package pipeline_display_driver_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n decodes hex digit n
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage
`default_nettype wire

// File: rtl/pipeline_display_driver_hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational 4-bit hex to active-low 7-segment decode.
//  Revision    : 1.0
// ============================================================================
module hex_to_seg7
    import pipeline_display_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);

    assign o_segments = HEX_SEG_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/pipeline_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_display_driver
//  Description : Scans a 16-bit snapshot of pc_in/reg_in onto a 4-digit
//                common-anode 7-segment display, one snapshot per frame.
//  Revision    : 1.0
// ============================================================================
module pipeline_display_driver
    import pipeline_display_driver_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES   = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] reg_in,
    input  logic        src_sel,
    input  logic        half_sel,
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        dp
);

    localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);

    logic [CNT_W-1:0] r_slot_cnt;
    logic [1:0]       r_digit_idx;
    logic [15:0]      r_snapshot;
    logic             r_half_flag;
    logic             r_load_pending;

    logic        w_tick;
    logic        w_load;
    logic        w_blank;
    logic [31:0] w_src;
    logic [15:0] w_slice;
    logic [3:0]  w_nibble;
    logic [6:0]  w_seg;

    assign w_tick   = (r_slot_cnt == CNT_W'(REFRESH_CYCLES - 1));
    // A frame boundary and a pending load in the same cycle collapse into one load
    assign w_load   = r_load_pending || (w_tick && (r_digit_idx == 2'd3));
    assign w_blank  = (r_slot_cnt < CNT_W'(BLANK_CYCLES));
    assign w_src    = src_sel ? reg_in : pc_in;
    assign w_slice  = half_sel ? w_src[31:16] : w_src[15:0];
    assign w_nibble = r_snapshot[4*r_digit_idx +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble   (w_nibble),
        .o_segments (w_seg)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot_cnt     <= '0;
            r_digit_idx    <= 2'd0;
            r_snapshot     <= 16'h0000;
            r_half_flag    <= 1'b0;
            r_load_pending <= 1'b1;
        end else begin
            r_slot_cnt <= w_tick ? '0 : r_slot_cnt + 1'b1;
            if (w_tick) begin
                r_digit_idx <= r_digit_idx + 2'd1;
            end
            if (w_load) begin
                r_snapshot     <= w_slice;
                r_half_flag    <= half_sel;
                r_load_pending <= 1'b0;
            end
        end
    end

    // Outputs lag the scan state by one cycle so they are glitch-free registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode    <= AN_OFF;
            segments <= SEG_BLANK;
            dp       <= 1'b1;
        end else if (w_blank) begin
            anode    <= AN_OFF;
            segments <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            anode    <= ~(4'b0001 << r_digit_idx);
            segments <= w_seg;
            dp       <= ~((r_digit_idx == 2'd3) && r_half_flag);
        end
    end

endmodule
`default_nettype wire
